// File: rtl/d_fwd_ctrl.sv
// Decode-stage hazard/forwarding controller: scoreboard of E/M/W writers -> D forwarding selects and stall.
// Optional stall cycle counter output enabled by defining D_FWD_STALL_CNT_EN.
module d_fwd_ctrl #(
   parameter int ADDR_W = 5,
   parameter int TNEW_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              d_valid,
   input  logic [ADDR_W-1:0] d_rs,
   input  logic [ADDR_W-1:0] d_rt,
   input  logic [TNEW_W-1:0] d_tuse_rs,
   input  logic [TNEW_W-1:0] d_tuse_rt,
   input  logic [ADDR_W-1:0] d_waddr,
   input  logic [TNEW_W-1:0] d_tnew,
   output logic [1:0]        mfrsd_c,
   output logic [1:0]        mfrtd_c,
   output logic              stall
`ifdef D_FWD_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   localparam logic [1:0] SEL_RF = 2'b00;
   localparam logic [1:0] SEL_AO_M = 2'b01;
   localparam logic [1:0] SEL_M4 = 2'b10;

   logic [ADDR_W-1:0] r_e_addr, r_m_addr, r_w_addr;
   logic [TNEW_W-1:0] r_e_tnew, r_m_tnew, r_w_tnew;

   logic [1:0][ADDR_W-1:0] w_src;
   logic [1:0][TNEW_W-1:0] w_tuse;
   logic [1:0][1:0]        w_sel;
   logic [1:0]             w_stall_src;
   logic                   w_stall;

   // Tnew counts down toward 0 and saturates there.
   function automatic logic [TNEW_W-1:0] dec(input logic [TNEW_W-1:0] t);
      return (t == '0) ? '0 : t - TNEW_W'(1);
   endfunction

   assign w_src[0]  = d_rs;
   assign w_src[1]  = d_rt;
   assign w_tuse[0] = d_tuse_rs;
   assign w_tuse[1] = d_tuse_rt;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         logic w_e_hit, w_m_hit, w_w_hit;

         assign w_e_hit = (w_src[gi] != '0) && (r_e_addr == w_src[gi]);
         assign w_m_hit = (w_src[gi] != '0) && (r_m_addr == w_src[gi]);
         assign w_w_hit = (w_src[gi] != '0) && (r_w_addr == w_src[gi]);

         assign w_stall_src[gi] = (w_e_hit && (r_e_tnew > w_tuse[gi])) ||
                                  (w_m_hit && (r_m_tnew > w_tuse[gi]));

         // Youngest writer wins; a hit in E is resolved later in E or by the stall.
         assign w_sel[gi] = !d_valid                        ? SEL_RF   :
                            w_e_hit                         ? SEL_RF   :
                            (w_m_hit && (r_m_tnew == '0))   ? SEL_AO_M :
                            w_m_hit                         ? SEL_RF   :
                            w_w_hit                         ? SEL_M4   :
                                                              SEL_RF;
      end
   endgenerate

   assign w_stall = d_valid && (w_stall_src[0] || w_stall_src[1]);
   assign stall   = w_stall;
   assign mfrsd_c = w_sel[0];
   assign mfrtd_c = w_sel[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_e_addr <= '0;
         r_e_tnew <= '0;
         r_m_addr <= '0;
         r_m_tnew <= '0;
         r_w_addr <= '0;
         r_w_tnew <= '0;
      end else begin
         if (w_stall || !d_valid) begin
            r_e_addr <= '0;
            r_e_tnew <= '0;
         end else begin
            r_e_addr <= d_waddr;
            r_e_tnew <= d_tnew;
         end
         r_m_addr <= r_e_addr;
         r_m_tnew <= dec(r_e_tnew);
         r_w_addr <= r_m_addr;
         r_w_tnew <= dec(r_m_tnew);
      end
   end

`ifdef D_FWD_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_d_fwd_ctrl.sv
// Directed bench for d_fwd_ctrl: hand-computed stall/select expectations per pipeline step.
module tb_d_fwd_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       d_valid;
   logic [4:0] d_rs, d_rt, d_waddr;
   logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
   logic [1:0] mfrsd_c, mfrtd_c;
   logic       stall;
`ifdef D_FWD_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   d_fwd_ctrl #(.ADDR_W(5), .TNEW_W(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .d_valid   (d_valid),
      .d_rs      (d_rs),
      .d_rt      (d_rt),
      .d_tuse_rs (d_tuse_rs),
      .d_tuse_rt (d_tuse_rt),
      .d_waddr   (d_waddr),
      .d_tnew    (d_tnew),
      .mfrsd_c   (mfrsd_c),
      .mfrtd_c   (mfrtd_c),
      .stall     (stall)
`ifdef D_FWD_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] trs, input logic [1:0] trt,
                        input logic [4:0] wa, input logic [1:0] tn);
      d_valid   = v;
      d_rs      = rs;
      d_rt      = rt;
      d_tuse_rs = trs;
      d_tuse_rt = trt;
      d_waddr   = wa;
      d_tnew    = tn;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      drive(1, 5, 0, 0, 0, 0, 0);
      check("rst_stall", stall, 0);
      check("rst_rs", mfrsd_c, 2'b00);
      check("rst_rt", mfrtd_c, 2'b00);
      tick();
      reset = 1'b0;
      drive(1, 5, 0, 0, 0, 0, 0);
      check("empty_stall", stall, 0);
      check("empty_rs", mfrsd_c, 2'b00);
      tick();

      // ALU writer r8 tnew1, then beq on r8 with tuse 0
      drive(1, 0, 0, 0, 0, 8, 1);
      check("alu_issue_stall", stall, 0);
      tick();                                   // E={8,1}
      drive(1, 8, 0, 0, 0, 10, 1);
      check("alu_E_stall", stall, 1);
      check("alu_E_rs", mfrsd_c, 2'b00);
      tick();                                   // E={0,0} M={8,0}
      check("alu_M_stall", stall, 0);
      check("alu_M_rs", mfrsd_c, 2'b01);
      drive(1, 8, 10, 0, 0, 10, 1);
      check("bubble_E_empty_stall", stall, 0);
      check("bubble_E_empty_rt", mfrtd_c, 2'b00);
      drive(1, 8, 0, 0, 0, 10, 1);
      tick();                                   // E={10,1} M={0,0} W={8,0}
      drive(1, 8, 10, 0, 0, 0, 0);
      check("alu_W_rs", mfrsd_c, 2'b10);
      check("new_E_stall", stall, 1);
      check("new_E_rt", mfrtd_c, 2'b00);
      drive(0, 8, 10, 0, 0, 0, 0);
      check("invalid_stall", stall, 0);
      check("invalid_rs", mfrsd_c, 2'b00);
      check("invalid_rt", mfrtd_c, 2'b00);
      tick();                                   // E={0,0} M={10,0} W={0,0}

      // Load r9 tnew2, consumer rt=9 tuse 1
      drive(1, 0, 0, 0, 0, 9, 2);
      tick();                                   // E={9,2}
      drive(1, 0, 9, 0, 1, 0, 0);
      check("load_E_stall", stall, 1);
      check("load_E_rt", mfrtd_c, 2'b00);
      tick();                                   // M={9,1}
      check("load_M_stall", stall, 0);
      check("load_M_rt", mfrtd_c, 2'b00);
      drive(1, 9, 9, 0, 1, 0, 0);
      check("load_M_tuse0_stall", stall, 1);
      check("load_M_tuse0_rs", mfrsd_c, 2'b00);
      drive(1, 0, 9, 0, 1, 0, 0);
      tick();                                   // W={9,0}
      check("load_W_rt", mfrtd_c, 2'b10);
      check("load_W_stall", stall, 0);

      // Two writers of r3: E beats M, later M beats W
      drive(1, 0, 0, 0, 0, 3, 0);
      tick();
      drive(1, 0, 0, 0, 0, 3, 0);
      tick();                                   // E={3,0} M={3,0}
      drive(1, 3, 3, 0, 0, 0, 0);
      check("r3_E_wins_rs", mfrsd_c, 2'b00);
      check("r3_E_stall", stall, 0);
      drive(0, 3, 3, 0, 0, 0, 0);
      tick();                                   // M={3,0} W={3,0}
      drive(1, 3, 3, 0, 0, 0, 0);
      check("r3_M_wins_rs", mfrsd_c, 2'b01);
      check("r3_M_wins_rt", mfrtd_c, 2'b01);
      check("r3_stall", stall, 0);

      // Register 0 writer never matches
      drive(1, 0, 0, 0, 0, 0, 2);
      tick();                                   // E={0,2}
      drive(1, 0, 0, 0, 0, 0, 0);
      check("r0_stall", stall, 0);
      check("r0_rs", mfrsd_c, 2'b00);
      check("r0_rt", mfrtd_c, 2'b00);

      // Tnew vs Tuse boundaries as writer r7 tnew3 ages
      drive(1, 0, 0, 0, 0, 7, 3);
      tick();                                   // E={7,3}
      drive(1, 7, 0, 2, 0, 0, 0);
      check("t3_tuse2_stall", stall, 1);
      drive(1, 7, 0, 3, 0, 0, 0);
      check("t3_tuse3_stall", stall, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();                                   // M={7,2}
      drive(1, 7, 0, 1, 0, 0, 0);
      check("t2_tuse1_stall", stall, 1);
      drive(1, 7, 0, 2, 0, 0, 0);
      check("t2_tuse2_stall", stall, 0);
      check("t2_M_rs", mfrsd_c, 2'b00);
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();                                   // W={7,1}
      drive(1, 7, 0, 0, 0, 0, 0);
      check("W_never_stalls", stall, 0);
      check("W_rs", mfrsd_c, 2'b10);

      // tnew 0 must stay 0 through dec()
      drive(1, 0, 0, 0, 0, 6, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();                                   // M={6,0}
      drive(1, 6, 6, 0, 0, 0, 0);
      check("sat_stall", stall, 0);
      check("sat_rs", mfrsd_c, 2'b01);

      // Asynchronous reset mid-cycle clears forwarding at once
      reset = 1'b1;
      #1;
      check("async_rst_rs", mfrsd_c, 2'b00);
      check("async_rst_rt", mfrtd_c, 2'b00);
      reset = 1'b0;
      drive(1, 6, 6, 0, 0, 0, 0);
      check("after_rst_rs", mfrsd_c, 2'b00);
      tick();

`ifdef D_FWD_STALL_CNT_EN
      reset = 1'b1;
      #1;
      check("cnt_rst", stall_cnt, 0);
      reset = 1'b0;
      drive(1, 0, 0, 0, 0, 11, 3);
      tick();                                   // E={11,3}
      drive(1, 11, 0, 0, 0, 0, 0);
      check("cnt_s1", stall, 1);
      tick();                                   // M={11,2}, count 1
      check("cnt_s2", stall, 1);
      tick();                                   // W={11,1}, count 2
      check("cnt_two", stall_cnt, 2);
      drive(1, 0, 0, 0, 0, 12, 1);
      tick();                                   // E={12,1}
      drive(1, 12, 0, 0, 0, 0, 0);
      check("cnt_s3", stall, 1);
      tick();                                   // M={12,0}, count 3
      check("cnt_three", stall_cnt, 3);
      check("cnt_fwd_rs", mfrsd_c, 2'b01);
      reset = 1'b1;
      #1;
      check("cnt_async_clr", stall_cnt, 0);
      check("cnt_async_rs", mfrsd_c, 2'b00);
      reset = 1'b0;
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/d_fwd_ctrl.md
Name: d_fwd_ctrl

Overview:
- Hazard and forwarding controller for the decode stage of the 5-stage MIPS pipeline.
- Keeps a small pipelined scoreboard of in-flight register writers in E, M and W: destination address plus remaining Tnew.
- From the scoreboard and the decode instruction's source registers and Tuse, it drives the D-stage forwarding selects (mfrsd_c, mfrtd_c) and the pipeline stall.
- It is the producer of the select codes consumed by the D-stage operand mux.

Parameters:
- ADDR_W, 5, register address width.
- TNEW_W, 2, width of Tnew/Tuse fields.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-high; clears the scoreboard
- d_valid  input  1  D-stage instruction is real (0 = bubble)
- d_rs  input  ADDR_W  D-stage rs address
- d_rt  input  ADDR_W  D-stage rt address
- d_tuse_rs  input  TNEW_W  cycles until rs is consumed (0 = used in D)
- d_tuse_rt  input  TNEW_W  cycles until rt is consumed
- d_waddr  input  ADDR_W  D-stage destination register (0 = none)
- d_tnew  input  TNEW_W  Tnew the instruction will have on entering E
- mfrsd_c  output  2  rs select: 2'b00 RF_RD1, 2'b01 AO_M, 2'b10 M4
- mfrtd_c  output  2  rt select: 2'b00 RF_RD2, 2'b01 AO_M, 2'b10 M4
- stall  output  1  freeze PC/F/D; inject bubble into E

Behaviour:
- State: three entries {addr, tnew} for E, M and W. Reset value of every entry is {0,0}.
- Outputs are combinational from the state and the D inputs, valid the same cycle. After reset: stall=0, both selects 2'b00.
- Matching, per source src in {rs, rt}:
  - X matches when X.addr == src and src != 0.
  - Register 0 never matches, never stalls, and always selects RF.
- Stall, per source:
  - stall_src = (E matches and E.tnew > tuse_src) or (M matches and M.tnew > tuse_src).
  - stall = d_valid and (stall_rs or stall_rt).
  - W entries never stall.
- Select, per source; the youngest writer wins:
  - If E matches: select 2'b00. Not forwardable in D; the E-stage mux resolves it, or stall is asserted.
  - Else if M matches and M.tnew == 0: select 2'b01.
  - Else if W matches: select 2'b10.
  - Else: select 2'b00.
  - M matches with M.tnew > 0: select 2'b00 (don't care; stall covers it when needed).
  - When d_valid=0: selects are 2'b00.
- Clock edge update, with dec(t) = (t == 0) ? 0 : t-1:
  - E <= (stall or !d_valid) ? {0,0} : {d_waddr, d_tnew}
  - M <= {E.addr, dec(E.tnew)}
  - W <= {M.addr, dec(M.tnew)}
- Simultaneous stall and any other input: the bubble insertion has priority. The D instruction is re-evaluated next cycle with unchanged inputs.
- Reset asserted mid-operation: all entries clear immediately (asynchronous). In-flight writers are forgotten, since the pipeline is flushed by the same reset.
- No wrap-around: Tnew saturates at 0.

Optional Feature:
- Macro: D_FWD_STALL_CNT_EN.
- Defined:
  - Extra output port stall_cnt, 32 bits.
  - Counts cycles with stall=1; reset to 0.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined:
  - Port absent, no counter logic.
  - Every other behaviour is identical.

Test Plan:
- Reset, then d_valid=1, d_rs=5, d_tuse_rs=0, empty scoreboard -> stall=0, mfrsd_c=00; after reset release all entries are 0.
- ALU writer (d_waddr=8, d_tnew=1) issued. Next cycle beq with d_rs=8, tuse 0 -> stall=1 for 1 cycle. Following cycle (writer in M, tnew 0): stall=0, mfrsd_c=01.
- Load (d_waddr=9, d_tnew=2), then consumer d_rt=9, tuse_rt=1 -> stall=1 for 1 cycle. Then writer in M with tnew 1 -> stall=0, mfrtd_c=00. Next cycle writer in W -> mfrtd_c=10.
- Writers for reg 3 in both M (tnew 0) and W, consumer d_rs=3 -> mfrsd_c=01, because the younger M entry wins. Consumer with d_rs=0 matching a d_waddr=0 writer -> no stall, select 00.
- Stall and d_valid=0 cycles -> E entry is {0,0} next cycle, M/W advance, tnew never underflows past 0.
- With D_FWD_STALL_CNT_EN defined, 3 stall cycles -> stall_cnt=3; asserting reset mid-count -> stall_cnt=0 and all selects 00 immediately.
